// File: rtl/ram_rd_stream_port.sv
// Valid/ready read front-end for port 0 of a 1rw1w byte-masked sync RAM.
// Optional same-cycle write forwarding from port 1: define RAM_RD_STREAM_WR_BYPASS_EN.
module ram_rd_stream_port #(
  parameter int width_p       = 32,
  parameter int els_p         = 16,
  parameter int buf_els_p     = 2,
  parameter int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p),
  parameter int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     rd_req_val_i,
  input  logic [addr_width_lp-1:0] rd_req_addr_i,
  output logic                     rd_req_rdy_o,
  output logic                     rd_resp_val_o,
  output logic [width_p-1:0]       rd_resp_data_o,
  input  logic                     rd_resp_rdy_i,
  output logic                     ram_v0_o,
  output logic [addr_width_lp-1:0] ram_addr0_o,
  input  logic [width_p-1:0]       ram_r0_data_i,
  input  logic                     wr_snoop_val_i,
  input  logic [addr_width_lp-1:0] wr_snoop_addr_i,
  input  logic [width_p-1:0]       wr_snoop_data_i,
  input  logic [mask_width_lp-1:0] wr_snoop_mask_i
);

  localparam int ptr_width_lp = (buf_els_p == 1) ? 1 : $clog2(buf_els_p);
  localparam int cnt_width_lp = $clog2(buf_els_p + 1);
  localparam int occ_width_lp = cnt_width_lp + 1;

  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    inflight_q, inflight_d;
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [width_p-1:0]      buf_q [buf_els_p];
  logic [width_p-1:0]      buf_d [buf_els_p];
  logic                    push, pop;
  logic [width_p-1:0]      capture_word;
  logic [occ_width_lp-1:0] occupancy;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(buf_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts reads already issued, so a capture always finds a free slot.
  assign occupancy      = occ_width_lp'(count_q) + occ_width_lp'(inflight_q);
  assign rd_resp_val_o  = (count_q != '0);
  assign rd_resp_data_o = buf_q[rd_ptr_q];
  assign pop            = rd_resp_val_o & rd_resp_rdy_i;
  assign push           = inflight_q;
  assign rd_req_rdy_o   = ~reset_i & ((occupancy < occ_width_lp'(buf_els_p)) | pop);
  assign ram_v0_o       = rd_req_val_i & rd_req_rdy_o;
  assign ram_addr0_o    = rd_req_addr_i;

`ifdef RAM_RD_STREAM_WR_BYPASS_EN
  logic                     hit_q, hit_d;
  logic [width_p-1:0]       snoop_data_q, snoop_data_d;
  logic [mask_width_lp-1:0] snoop_mask_q, snoop_mask_d;

  always_comb begin
    hit_d        = ram_v0_o & wr_snoop_val_i & (wr_snoop_addr_i == rd_req_addr_i);
    snoop_data_d = wr_snoop_data_i;
    snoop_mask_d = wr_snoop_mask_i;
    capture_word = ram_r0_data_i;
    // RAM returns pre-write data on a collision; overlay the bytes written that cycle.
    for (int unsigned i = 0; i < mask_width_lp; i++) begin
      if (hit_q & snoop_mask_q[i]) begin
        capture_word[8*i +: 8] = snoop_data_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
    snoop_data_q <= snoop_data_d;
    snoop_mask_q <= snoop_mask_d;
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^{wr_snoop_val_i, wr_snoop_addr_i, wr_snoop_data_i, wr_snoop_mask_i};
  assign capture_word = ram_r0_data_i;
`endif

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_d      = buf_q;
    inflight_d = ram_v0_o;
    if (push) begin
      buf_d[wr_ptr_q] = capture_word;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_ram_rd_stream_port.sv
// Bench for ram_rd_stream_port: depth-2 and depth-3 instances share stimulus and a RAM model.
module tb_ram_rd_stream_port;
  localparam int W   = 32;
  localparam int ELS = 16;
  localparam int AW  = 4;
  localparam int MW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          resp_rdy = 1'b0;
  logic          snoop_val = 1'b0;
  logic [AW-1:0] snoop_addr = '0;
  logic [W-1:0]  snoop_data = '0;
  logic [MW-1:0] snoop_mask = '0;
  logic [W-1:0]  ram [ELS];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Port-1 byte-masked write; reads elsewhere see the pre-write word in the same edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ELS; i++) ram[i] <= 32'h9E3779B9 * (i + 1);
    end else if (snoop_val) begin
      for (int i = 0; i < MW; i++)
        if (snoop_mask[i]) ram[snoop_addr][8*i +: 8] <= snoop_data[8*i +: 8];
    end
  end

  function automatic logic [W-1:0] expect_word(input logic [AW-1:0] a);
    logic [W-1:0] w;
    w = ram[a];
`ifdef RAM_RD_STREAM_WR_BYPASS_EN
    if (snoop_val && snoop_addr == a)
      for (int i = 0; i < MW; i++)
        if (snoop_mask[i]) w[8*i +: 8] = snoop_data[8*i +: 8];
`endif
    return w;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int NB = 2 + k;
    logic          req_rdy, resp_val, v0;
    logic [AW-1:0] a0;
    logic [W-1:0]  resp_data, r0_data;
    logic [W-1:0]  q_data [$];
    int            q_cyc [$];
    logic          exp_val, exp_rdy;
    logic [W-1:0]  exp_data;

    ram_rd_stream_port #(.width_p(W), .els_p(ELS), .buf_els_p(NB)) dut (
      .clk_i(clk), .reset_i(reset),
      .rd_req_val_i(req_val), .rd_req_addr_i(req_addr), .rd_req_rdy_o(req_rdy),
      .rd_resp_val_o(resp_val), .rd_resp_data_o(resp_data), .rd_resp_rdy_i(resp_rdy),
      .ram_v0_o(v0), .ram_addr0_o(a0), .ram_r0_data_i(r0_data),
      .wr_snoop_val_i(snoop_val), .wr_snoop_addr_i(snoop_addr),
      .wr_snoop_data_i(snoop_data), .wr_snoop_mask_i(snoop_mask)
    );

    // RAM read data is garbage except exactly one cycle after an issue.
    always @(posedge clk) r0_data <= v0 ? ram[a0] : $urandom;

    // Reference: queue of accepted reads, each visible two cycles after acceptance.
    always @(negedge clk) begin
      exp_val = 1'b0;
      if (q_data.size() != 0) exp_val = (q_cyc[0] <= cyc);
      exp_data = exp_val ? q_data[0] : '0;
      exp_rdy = !reset && ((q_data.size() < NB) || (exp_val && resp_rdy));
    end

    always @(posedge clk) begin
      if (reset) begin
        q_data.delete();
        q_cyc.delete();
      end else begin
        if (exp_val && resp_rdy) begin
          void'(q_data.pop_front());
          void'(q_cyc.pop_front());
        end
        if (req_val && exp_rdy) begin
          q_data.push_back(expect_word(req_addr));
          q_cyc.push_back(cyc + 2);
        end
      end
    end
  end

  task automatic wait_neg(); @(negedge clk); #1; endtask
  task automatic wait_pos(); @(posedge clk); #1; endtask

  task automatic test_reset();
    reset = 1'b1; req_val = 1'b1; req_addr = 4'd2; resp_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_neg();
      n_cmp++;
      if (g[0].resp_val !== 1'b0 || g[0].req_rdy !== 1'b0 || g[0].v0 !== 1'b0 ||
          g[1].resp_val !== 1'b0 || g[1].req_rdy !== 1'b0 || g[1].v0 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset j%0d: val=%b/%b rdy=%b/%b v0=%b/%b, need all 0", j,
                 g[0].resp_val, g[1].resp_val, g[0].req_rdy, g[1].req_rdy, g[0].v0, g[1].v0);
      end
      wait_pos();
    end
    reset = 1'b0; req_val = 1'b0;
    wait_pos();
  endtask

  task automatic test_single();
    snoop_val = 1'b1; snoop_addr = 4'd5; snoop_data = 32'hDEADBEEF; snoop_mask = 4'hF;
    wait_pos();
    snoop_val = 1'b0;
    for (int j = 0; j < 4; j++) begin
      req_val = (j == 0); req_addr = 4'd5; resp_rdy = 1'b1;
      wait_neg();
      n_cmp++;
      if (g[0].req_rdy !== g[0].exp_rdy || g[0].v0 !== (req_val & g[0].exp_rdy) ||
          g[0].resp_val !== g[0].exp_val || (g[0].exp_val && g[0].resp_data !== g[0].exp_data)) begin
        n_fail++;
        $display("FAIL single_model j%0d: rdy=%b v0=%b val=%b data=%h, need rdy=%b val=%b data=%h", j,
                 g[0].req_rdy, g[0].v0, g[0].resp_val, g[0].resp_data, g[0].exp_rdy, g[0].exp_val, g[0].exp_data);
      end
      n_cmp++;
      if ((j == 0 && (g[0].v0 !== 1'b1 || g[0].a0 !== 4'd5)) ||
          (j == 2 && (g[0].resp_val !== 1'b1 || g[0].resp_data !== 32'hDEADBEEF)) ||
          ((j == 1 || j == 3) && g[0].resp_val !== 1'b0)) begin
        n_fail++;
        $display("FAIL single_fixed j%0d: v0=%b addr=%0d val=%b data=%h, need v0@0 addr 5, data deadbeef@2 only",
                 j, g[0].v0, g[0].a0, g[0].resp_val, g[0].resp_data);
      end
      wait_pos();
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 11; j++) begin
      req_val = (j < 8); req_addr = AW'(j); resp_rdy = 1'b1;
      wait_neg();
      n_cmp++;
      if (g[0].req_rdy !== g[0].exp_rdy || g[0].v0 !== (req_val & g[0].exp_rdy) ||
          (g[0].v0 && g[0].a0 !== req_addr) ||
          g[0].resp_val !== g[0].exp_val || (g[0].exp_val && g[0].resp_data !== g[0].exp_data)) begin
        n_fail++;
        $display("FAIL stream_model j%0d: rdy=%b val=%b data=%h, need rdy=%b val=%b data=%h", j,
                 g[0].req_rdy, g[0].resp_val, g[0].resp_data, g[0].exp_rdy, g[0].exp_val, g[0].exp_data);
      end
      if (j >= 1 && j < 8) begin
        n_cmp++;
        if (g[0].req_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_rdy j%0d: rdy=%b, need 1", j, g[0].req_rdy);
        end
      end
      if (j >= 2 && j < 10) begin
        n_cmp++;
        if (g[0].resp_val !== 1'b1 || g[0].resp_data !== ram[j-2]) begin
          n_fail++;
          $display("FAIL stream_resp j%0d: val=%b data=%h, need 1 %h", j, g[0].resp_val, g[0].resp_data, ram[j-2]);
        end
      end
      wait_pos();
    end
  endtask

  task automatic test_backpressure();
    int idx = 1;
    int acc = 0;
    int got = 0;
    logic [W-1:0] want [3];
    want[0] = ram[1]; want[1] = ram[2]; want[2] = ram[3];
    resp_rdy = 1'b0;
    for (int j = 0; j < 14; j++) begin
      if (j == 6) resp_rdy = 1'b1;
      req_val = (idx <= 3); req_addr = AW'(idx);
      wait_neg();
      n_cmp++;
      if (g[0].req_rdy !== g[0].exp_rdy || g[0].v0 !== (req_val & g[0].exp_rdy) ||
          g[0].resp_val !== g[0].exp_val || (g[0].exp_val && g[0].resp_data !== g[0].exp_data)) begin
        n_fail++;
        $display("FAIL bp_model j%0d: rdy=%b val=%b data=%h, need rdy=%b val=%b data=%h", j,
                 g[0].req_rdy, g[0].resp_val, g[0].resp_data, g[0].exp_rdy, g[0].exp_val, g[0].exp_data);
      end
      if (j < 6 && g[0].resp_val === 1'b1) begin
        n_cmp++;
        if (g[0].resp_data !== want[0]) begin
          n_fail++;
          $display("FAIL bp_head j%0d: data=%h, need %h", j, g[0].resp_data, want[0]);
        end
      end
      if (j == 5) begin
        n_cmp++;
        if (acc != 2 || g[0].req_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_stall: accepted=%0d rdy=%b, need 2 0", acc, g[0].req_rdy);
        end
      end
      if (g[0].resp_val === 1'b1 && resp_rdy) begin
        n_cmp++;
        if (got > 2 || g[0].resp_data !== want[got]) begin
          n_fail++;
          $display("FAIL bp_order #%0d: data=%h, need %h", got, g[0].resp_data, (got > 2) ? 32'h0 : want[got]);
        end
        got++;
      end
      if (req_val && g[0].exp_rdy) begin acc++; idx++; end
      wait_pos();
    end
    n_cmp++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL bp_count: responses=%0d, need 3", got);
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] old6;
    logic [W-1:0] coll;
`ifdef RAM_RD_STREAM_WR_BYPASS_EN
    coll = 32'h11BB33DD;
`else
    coll = 32'h11223344;
`endif
    snoop_val = 1'b1; snoop_addr = 4'd3; snoop_data = 32'h11223344; snoop_mask = 4'hF;
    wait_pos();
    old6 = ram[6];
    for (int j = 0; j < 10; j++) begin
      req_val = (j == 0 || j == 3 || j == 6); req_addr = (j == 6) ? 4'd6 : 4'd3; resp_rdy = 1'b1;
      snoop_val = (j == 0 || j == 7); snoop_addr = (j == 7) ? 4'd6 : 4'd3;
      snoop_data = (j == 7) ? 32'h0 : 32'hAABBCCDD; snoop_mask = (j == 7) ? 4'hF : 4'b0101;
      wait_neg();
      n_cmp++;
      if (g[0].req_rdy !== g[0].exp_rdy || g[0].resp_val !== g[0].exp_val ||
          (g[0].exp_val && g[0].resp_data !== g[0].exp_data)) begin
        n_fail++;
        $display("FAIL coll_model j%0d: val=%b data=%h, need val=%b data=%h", j,
                 g[0].resp_val, g[0].resp_data, g[0].exp_val, g[0].exp_data);
      end
      if (j == 2 || j == 5 || j == 8) begin
        n_cmp++;
        if (g[0].resp_val !== 1'b1 ||
            g[0].resp_data !== ((j == 2) ? coll : (j == 5) ? 32'h11BB33DD : old6)) begin
          n_fail++;
          $display("FAIL coll_fixed j%0d: val=%b data=%h, need 1 %h", j, g[0].resp_val, g[0].resp_data,
                   (j == 2) ? coll : (j == 5) ? 32'h11BB33DD : old6);
        end
      end
      wait_pos();
    end
    snoop_val = 1'b0;
  endtask

  task automatic test_reset_midstream();
    resp_rdy = 1'b0;
    for (int j = 0; j < 9; j++) begin
      reset = (j == 2);
      req_val = (j == 0 || j == 1 || j == 4);
      req_addr = (j == 0) ? 4'd9 : (j == 1) ? 4'd10 : 4'd4;
      resp_rdy = (j >= 4);
      wait_neg();
      n_cmp++;
      if (g[0].req_rdy !== g[0].exp_rdy || g[0].v0 !== (req_val & g[0].exp_rdy) ||
          (!reset && (g[0].resp_val !== g[0].exp_val ||
                      (g[0].exp_val && g[0].resp_data !== g[0].exp_data)))) begin
        n_fail++;
        $display("FAIL rst_model j%0d: rdy=%b val=%b data=%h, need rdy=%b val=%b data=%h", j,
                 g[0].req_rdy, g[0].resp_val, g[0].resp_data, g[0].exp_rdy, g[0].exp_val, g[0].exp_data);
      end
      if (j >= 3) begin
        n_cmp++;
        if ((j == 6 && (g[0].resp_val !== 1'b1 || g[0].resp_data !== ram[4])) ||
            (j != 6 && (g[0].resp_val !== 1'b0 || g[1].resp_val !== 1'b0))) begin
          n_fail++;
          $display("FAIL rst_fixed j%0d: val=%b/%b data=%h, need val only at j6 with %h", j,
                   g[0].resp_val, g[1].resp_val, g[0].resp_data, ram[4]);
        end
      end
      wait_pos();
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap_random();
    int acc1 = 0;
    int got1 = 0;
    for (int j = 0; j < 90; j++) begin
      req_val = (j < 70) && ($urandom_range(0, 3) != 0);
      req_addr = AW'($urandom_range(0, ELS - 1));
      resp_rdy = (j >= 70) || ($urandom_range(0, 2) != 0);
      snoop_val = (j < 70) && ($urandom_range(0, 2) == 0);
      snoop_addr = $urandom_range(0, 1) ? req_addr : AW'($urandom_range(0, ELS - 1));
      snoop_data = $urandom;
      snoop_mask = MW'($urandom);
      wait_neg();
      n_cmp++;
      if (g[0].req_rdy !== g[0].exp_rdy || g[0].v0 !== (req_val & g[0].exp_rdy) ||
          g[0].resp_val !== g[0].exp_val || (g[0].exp_val && g[0].resp_data !== g[0].exp_data)) begin
        n_fail++;
        $display("FAIL rand2 j%0d: rdy=%b val=%b data=%h, need rdy=%b val=%b data=%h", j,
                 g[0].req_rdy, g[0].resp_val, g[0].resp_data, g[0].exp_rdy, g[0].exp_val, g[0].exp_data);
      end
      n_cmp++;
      if (g[1].req_rdy !== g[1].exp_rdy || g[1].v0 !== (req_val & g[1].exp_rdy) ||
          g[1].resp_val !== g[1].exp_val || (g[1].exp_val && g[1].resp_data !== g[1].exp_data)) begin
        n_fail++;
        $display("FAIL rand3 j%0d: rdy=%b val=%b data=%h, need rdy=%b val=%b data=%h", j,
                 g[1].req_rdy, g[1].resp_val, g[1].resp_data, g[1].exp_rdy, g[1].exp_val, g[1].exp_data);
      end
      if (req_val && g[1].exp_rdy) acc1++;
      if (g[1].resp_val === 1'b1 && resp_rdy) got1++;
      wait_pos();
    end
    snoop_val = 1'b0;
    n_cmp++;
    if (got1 != acc1 || got1 < 10) begin
      n_fail++;
      $display("FAIL rand3_count: responses=%0d, need %0d (at least 10)", got1, acc1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_reset_midstream();
    test_wrap_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, need completion before 200000");
    $fatal(1);
  end
endmodule

// File: doc/ram_rd_stream_port.md
Name: ram_rd_stream_port

Overview:
- Valid/ready read front-end for the read/write port (port 0) of the banked 1rw1w byte-masked sync RAM.
- Accepts a stream of read requests and issues each to the RAM with a fixed 1-cycle access.
- Captures the returned word into a small response buffer and delivers it on a valid/ready response channel, so clients never lose data under backpressure.
- Sits between a read client (e.g. a TX payload fetch engine) and the RAM. The RAM's port 0 write strobe is tied low by the integrator; port 1 stays the write side.

Parameters:
- width_p, -1, data word width in bits; must be a multiple of 8.
- els_p, -1, number of RAM words.
- buf_els_p, 2, response buffer depth; legal values are 2 or more.
- addr_width_lp, BSG_SAFE_CLOG2(els_p), address width (derived).
- mask_width_lp, width_p/8, byte-mask width (derived).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- rd_req_val_i  in  1  read request valid
- rd_req_addr_i  in  addr_width_lp  read address
- rd_req_rdy_o  out  1  request accepted when val & rdy
- rd_resp_val_o  out  1  response valid
- rd_resp_data_o  out  width_p  response data
- rd_resp_rdy_i  in  1  response consumed when val & rdy
- ram_v0_o  out  1  RAM port 0 valid (read only)
- ram_addr0_o  out  addr_width_lp  RAM port 0 address
- ram_r0_data_i  in  width_p  RAM port 0 read data, valid 1 cycle after ram_v0_o
- wr_snoop_val_i  in  1  RAM port 1 write strobe (w1 & v1), used only with the optional feature
- wr_snoop_addr_i  in  addr_width_lp  port 1 write address
- wr_snoop_data_i  in  width_p  port 1 write data
- wr_snoop_mask_i  in  mask_width_lp  port 1 byte mask

Behaviour:
- Clock is clk_i; reset_i is synchronous, active-high. Reset clears all state: buffer count = 0, inflight = 0, rd_resp_val_o = 0, ram_v0_o = 0, rd_req_rdy_o = 0.
- Request acceptance:
  - rd_req_rdy_o = ~reset_i & ((count + inflight < buf_els_p) | (rd_resp_val_o & rd_resp_rdy_i)).
  - This is a deliberate combinational path from rd_resp_rdy_i, so depth 2 sustains 1 read/cycle.
- RAM issue (combinational):
  - ram_v0_o = rd_req_val_i & rd_req_rdy_o.
  - ram_addr0_o = rd_req_addr_i.
- Inflight tracking:
  - inflight register <= ram_v0_o.
  - A read issued in cycle T has its data captured from ram_r0_data_i at the end of T+1, unconditionally; space is guaranteed by the ready rule.
  - The RAM output is never sampled in any other cycle.
- Response buffer:
  - FIFO of buf_els_p entries with circular read/write pointers that wrap at buf_els_p.
  - rd_resp_val_o = (count != 0); rd_resp_data_o = head entry.
  - Minimum request-to-response latency is 2 cycles: accepted at T, rd_resp_val_o at T+2.
  - Responses return in request order.
- Simultaneous push (capture) and pop (handshake) in one cycle: count unchanged, both pointers advance.
  - Push into an empty buffer is not visible until the next cycle; there is no same-cycle fall-through.
- Full: count == buf_els_p, or count + inflight == buf_els_p with no pop, forces rd_req_rdy_o = 0. rd_resp_data_o stays stable while rd_resp_val_o & ~rd_resp_rdy_i.
- Reset mid-operation: inflight data arriving in the cycle after reset is discarded. Buffered responses are dropped without handshake.
- The block holds no per-address state; there are no other state machines.

Optional Feature:
- Macro: RAM_RD_STREAM_WR_BYPASS_EN.
- Defined:
  - In the issue cycle T, if ram_v0_o & wr_snoop_val_i & (wr_snoop_addr_i == rd_req_addr_i), register a hit flag, the snoop data and the snoop mask.
  - At T+1 the captured word is formed byte-wise: byte i = hit & mask[i] ? snoop byte i : ram_r0_data_i byte i.
  - The response therefore reflects the port 1 write made in the same cycle.
  - Writes at T+1 or later are never forwarded.
- Undefined: the captured word is ram_r0_data_i verbatim (pre-write data on a same-cycle collision). The snoop inputs are unused and their registers are not built.

Test Plan:
- Single read: RAM word 5 = 0xDEADBEEF, request addr 5 at cycle 10 with rd_resp_rdy_i = 1 -> ram_v0_o = 1 at cycle 10, rd_resp_val_o = 1 with data 0xDEADBEEF at cycle 12, one response only.
- Streaming: back-to-back requests to addrs 0..7 holding val, rd_resp_rdy_i = 1, buf_els_p = 2 -> rd_req_rdy_o held 1 after the first cycle, eight in-order responses on eight consecutive cycles.
- Backpressure: rd_resp_rdy_i = 0, request addrs 1, 2, 3 continuously -> only 2 accepted, rd_req_rdy_o = 0 afterwards, head data stable. Release rdy -> words 1, 2, then 3 accepted and returned in order.
- Collision with RAM_RD_STREAM_WR_BYPASS_EN defined: old word 3 = 0x11223344, read addr 3 while port 1 writes 0xAABBCCDD with mask 0b0101 to addr 3 -> response 0x11BB33DD. Macro undefined -> response 0x11223344.
- Reset mid-stream: reset_i high for 1 cycle with 1 buffered entry and 1 inflight -> rd_resp_val_o = 0 for the cycle after reset and no stale response ever appears. The next read of addr 4 returns correctly 2 cycles after acceptance.
- Pointer wrap: buf_els_p = 3, 10 reads with random rd_resp_rdy_i -> all 10 responses match a reference model and are in order; count never exceeds 3.
